// File: rtl/rmw_sequencer_if.sv
// Purpose: groups the control, memory-bus and ALU signals of the read-modify-write sequencer.
// Latency: none (wiring only).
// Backpressure: the memory side stalls through mem_ready; the control side has none (start is ignored while busy).
// Ports:
//   control: start, op, addr, carry_in -> busy, done, error, flags_we, flags_val, flags_mask
//   memory : mem_addr, mem_rd, mem_wr, mem_wdata -> mem_rdata, mem_ready
//   alu    : alu_op, alu_a, alu_b, alu_cin -> alu_result, alu_flags
// master = the sequencer, slave = the surrounding control unit, memory and ALU.
interface rmw_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [4:0]        op;
  logic [ADDR_W-1:0] addr;
  logic              carry_in;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic [4:0]        alu_op;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic              alu_cin;
  logic [7:0]        alu_result;
  logic [3:0]        alu_flags;
  logic              flags_we;
  logic [3:0]        flags_val;
  logic [3:0]        flags_mask;

  modport master (
    input  start, op, addr, carry_in, mem_rdata, mem_ready, alu_result, alu_flags,
    output busy, done, error, mem_addr, mem_rd, mem_wr, mem_wdata,
           alu_op, alu_a, alu_b, alu_cin, flags_we, flags_val, flags_mask
  );

  modport slave (
    output start, op, addr, carry_in, mem_rdata, mem_ready, alu_result, alu_flags,
    input  busy, done, error, mem_addr, mem_rd, mem_wr, mem_wdata,
           alu_op, alu_a, alu_b, alu_cin, flags_we, flags_val, flags_mask
  );
endinterface

// File: rtl/rmw_sequencer.sv
// Purpose: executes 6502 memory read-modify-write ops (INC/DEC/ASL/LSR/ROL/ROR): read, modify via external ALU, dummy write, final write.
// Latency: done 5 cycles after the start edge with zero memory wait states (4 without the dummy write); +1 per wait cycle.
// Backpressure: each memory access holds its request, address and data until a mem_ready edge; start is ignored unless idle.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus       : rmw_sequencer_if master view (control handshake, memory bus, ALU operands/result, P-flag update)
module rmw_sequencer #(
  parameter int ADDR_W      = 16,
  parameter bit DUMMY_WRITE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  rmw_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_WRITE_OLD,
    S_WRITE_NEW,
    S_DONE
  } state_t;

  localparam logic [4:0] OP_INC = 5'd5;
  localparam logic [4:0] OP_DEC = 5'd6;
  localparam logic [4:0] OP_ROR = 5'd10;

  state_t            state;
  logic [4:0]        op_q;
  logic              cin_q;
  logic [7:0]        result_q;
  logic [2:0]        nzc_q;      // latched ALU {N,Z,C}; V is never forwarded

  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [7:0]        mem_wdata_q;
  logic [4:0]        alu_op_q;
  logic [7:0]        alu_a_q;    // doubles as the operand store while in MODIFY
  logic              alu_cin_q;
  logic              flags_we_q;
  logic [3:0]        flags_val_q;
  logic [3:0]        flags_mask_q;

  logic              op_legal;
  logic              op_is_incdec;

  assign op_legal     = (bus.op >= OP_INC) && (bus.op <= OP_ROR);
  assign op_is_incdec = (op_q == OP_INC) || (op_q == OP_DEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= '0;
      cin_q        <= 1'b0;
      result_q     <= '0;
      nzc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_cin_q    <= 1'b0;
      flags_we_q   <= 1'b0;
      flags_val_q  <= '0;
      flags_mask_q <= '0;
    end else begin
      // single-cycle pulses
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      flags_we_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (op_legal) begin
              op_q       <= bus.op;
              cin_q      <= bus.carry_in;
              mem_addr_q <= bus.addr;   // address register holds addr for all three accesses
              mem_rd_q   <= 1'b1;
              busy_q     <= 1'b1;
              state      <= S_READ;
            end else begin
              error_q <= 1'b1;
            end
          end
        end

        S_READ: begin
          if (bus.mem_ready) begin
            mem_rd_q  <= 1'b0;
            alu_op_q  <= op_q;
            alu_a_q   <= bus.mem_rdata;
            alu_cin_q <= cin_q;
            state     <= S_MODIFY;
          end
        end

        S_MODIFY: begin
          // ALU is combinational on alu_op/alu_a/alu_cin, so its outputs are valid here
          result_q  <= bus.alu_result;
          nzc_q     <= {bus.alu_flags[3], bus.alu_flags[1], bus.alu_flags[0]};
          alu_op_q  <= '0;
          alu_a_q   <= '0;
          alu_cin_q <= 1'b0;
          mem_wr_q  <= 1'b1;
          if (DUMMY_WRITE) begin
            mem_wdata_q <= alu_a_q;
            state       <= S_WRITE_OLD;
          end else begin
            mem_wdata_q <= bus.alu_result;
            state       <= S_WRITE_NEW;
          end
        end

        S_WRITE_OLD: begin
          if (bus.mem_ready) begin
            mem_wdata_q <= result_q;
            state       <= S_WRITE_NEW;
          end
        end

        S_WRITE_NEW: begin
          if (bus.mem_ready) begin
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            mem_addr_q   <= '0;
            done_q       <= 1'b1;
            flags_we_q   <= 1'b1;
            flags_val_q  <= {nzc_q[2], 1'b0, nzc_q[1], nzc_q[0]};
            flags_mask_q <= op_is_incdec ? 4'b1010 : 4'b1011;
            state        <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q       <= 1'b0;
          flags_val_q  <= '0;
          flags_mask_q <= '0;
          state        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = 8'h00;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.flags_we   = flags_we_q;
  assign bus.flags_val  = flags_val_q;
  assign bus.flags_mask = flags_mask_q;

endmodule

// File: tb/tb_rmw_sequencer.sv
// Purpose: self-checking bench for rmw_sequencer, with and without the dummy write.
// Latency: n/a.
// Backpressure: memory responder inserts wait states (none, random, fixed read waits, or write stall).
module tb_rmw_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  rmw_sequencer_if #(.ADDR_W(16)) if0 ();
  rmw_sequencer_if #(.ADDR_W(16)) if1 ();

  rmw_sequencer #(.ADDR_W(16), .DUMMY_WRITE(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  rmw_sequencer #(.ADDR_W(16), .DUMMY_WRITE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  logic [7:0] mem [0:65535];

  // Combinational ALU: V output is deliberately junk so V-forcing is visible.
  function automatic logic [11:0] alu_model(input logic [4:0] o, input logic [7:0] a, input logic ci);
    logic [7:0] r;
    logic c;
    r = 8'h00;
    c = 1'b0;
    case (o)
      5'd5:  r = a + 8'd1;
      5'd6:  r = a - 8'd1;
      5'd7:  begin r = {a[6:0], 1'b0}; c = a[7]; end
      5'd8:  begin r = {1'b0, a[7:1]}; c = a[0]; end
      5'd9:  begin r = {a[6:0], ci};   c = a[7]; end
      5'd10: begin r = {ci, a[7:1]};   c = a[0]; end
      default: r = 8'h00;
    endcase
    return {r, r[7], a[6] ^ o[0], (r == 8'h00), c};
  endfunction

  assign {if0.alu_result, if0.alu_flags} = alu_model(if0.alu_op, if0.alu_a, if0.alu_cin);
  assign {if1.alu_result, if1.alu_flags} = alu_model(if1.alu_op, if1.alu_a, if1.alu_cin);
  assign if0.mem_rdata = mem[if0.mem_addr];
  assign if1.mem_rdata = mem[if1.mem_addr];

  // Wait-state generator for dut0: 0=always ready, 1=random, 2=rd_wait_req read waits, 3=stall writes
  int   wait_mode   = 0;
  int   rd_wait_req = 0;
  int   rd_run      = 0;
  logic ready0      = 1'b1;
  assign if0.mem_ready = ready0;
  assign if1.mem_ready = 1'b1;

  always @(negedge clk) begin
    rd_run <= if0.mem_rd ? rd_run + 1 : 0;
    case (wait_mode)
      0: ready0 <= 1'b1;
      1: ready0 <= ($urandom_range(0, 2) != 0);
      2: ready0 <= !(if0.mem_rd && (rd_run + 1 <= rd_wait_req));
      3: ready0 <= !if0.mem_wr;
      default: ready0 <= 1'b1;
    endcase
  end

  // Bus logs
  int         rd0_n = 0;
  logic [15:0] rd0_addr = '0;
  logic [15:0] wq0_a[$];
  logic [7:0]  wq0_d[$];
  int         waits0 = 0;
  int         rd1_n = 0;
  logic [15:0] wq1_a[$];
  logic [7:0]  wq1_d[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (if0.mem_rd && if0.mem_ready) begin
        rd0_n    <= rd0_n + 1;
        rd0_addr <= if0.mem_addr;
      end
      if (if0.mem_wr && if0.mem_ready) begin
        wq0_a.push_back(if0.mem_addr);
        wq0_d.push_back(if0.mem_wdata);
      end
      if ((if0.mem_rd || if0.mem_wr) && !if0.mem_ready) waits0 <= waits0 + 1;
      if (if1.mem_rd) rd1_n <= rd1_n + 1;
      if (if1.mem_wr) begin
        wq1_a.push_back(if1.mem_addr);
        wq1_d.push_back(if1.mem_wdata);
      end
    end
  end

  // Reference: instruction semantics in plain arithmetic.
  function automatic void ref_model(input int opc, input int val, input int cin,
                                    output int res, output logic [3:0] fv, output logic [3:0] fm);
    int c;
    c = 0;
    case (opc)
      5:  res = (val + 1) % 256;
      6:  res = (val + 255) % 256;
      7:  begin res = (val * 2) % 256;         c = val / 128; end
      8:  begin res = val / 2;                 c = val % 2;   end
      9:  begin res = (val * 2) % 256 + cin;   c = val / 128; end
      default: begin res = val / 2 + cin * 128; c = val % 2; end
    endcase
    fv = {(res >= 128), 1'b0, (res == 0), (c == 1)};
    fm = (opc <= 6) ? 4'b1010 : 4'b1011;
  endfunction

  function automatic logic [51:0] outs0();
    return {if0.busy, if0.done, if0.error, if0.mem_rd, if0.mem_wr, if0.flags_we, if0.mem_addr,
            if0.mem_wdata, if0.alu_op, if0.alu_a, if0.alu_cin, if0.flags_val, if0.flags_mask};
  endfunction

  function automatic logic [51:0] outs1();
    return {if1.busy, if1.done, if1.error, if1.mem_rd, if1.mem_wr, if1.flags_we, if1.mem_addr,
            if1.mem_wdata, if1.alu_op, if1.alu_a, if1.alu_cin, if1.flags_val, if1.flags_mask};
  endfunction

  task automatic run_op0(input logic [4:0] opc, input logic [15:0] a, input logic [7:0] v,
                         input logic cin, input int mode, input int rw, input string nm);
    int res, cyc, rb, wb, wtb, rd_hi, alu_hi, bad;
    logic [3:0] fv, fm;
    bit got;
    ref_model(int'(opc), int'(v), int'(cin), res, fv, fm);
    mem[a] = v;
    wait_mode = mode;
    rd_wait_req = rw;
    @(negedge clk);
    rb = rd0_n; wb = wq0_a.size(); wtb = waits0;
    if0.start = 1'b1; if0.op = opc; if0.addr = a; if0.carry_in = cin;
    @(posedge clk); #1;
    if0.start = 1'b0; if0.op = 5'($urandom); if0.addr = 16'($urandom); if0.carry_in = 1'($urandom);
    cyc = 0; got = 0; rd_hi = 0; alu_hi = 0; bad = 0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (if0.mem_rd) rd_hi++;
      if (if0.mem_rd && if0.mem_wr) bad++;
      if ((if0.mem_rd || if0.mem_wr) && if0.mem_addr !== a) bad++;
      if (!if0.done && !if0.busy) bad++;
      if (if0.alu_op != 5'd0) begin
        alu_hi++;
        if (if0.alu_op !== opc || if0.alu_a !== v || if0.alu_cin !== cin || if0.alu_b !== 8'h00) bad++;
      end
      if (if0.done) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL %s timeout: no done within %0d cycles", nm, cyc); end
    checks++; if (cyc !== 5 + (waits0 - wtb)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc, 5 + (waits0 - wtb)); end
    checks++; if (if0.flags_we !== 1'b1 || if0.busy !== 1'b1) begin errors++; $display("FAIL %s done_strobes: flags_we=%b busy=%b expected 1 1", nm, if0.flags_we, if0.busy); end
    checks++; if (if0.flags_val !== fv) begin errors++; $display("FAIL %s flags_val: got %b expected %b", nm, if0.flags_val, fv); end
    checks++; if (if0.flags_mask !== fm) begin errors++; $display("FAIL %s flags_mask: got %b expected %b", nm, if0.flags_mask, fm); end
    checks++; if (bad != 0) begin errors++; $display("FAIL %s bus_alu_rules: %0d violations expected 0", nm, bad); end
    checks++; if (alu_hi != 1) begin errors++; $display("FAIL %s modify_cycles: got %0d expected 1", nm, alu_hi); end
    if (mode == 2) begin
      checks++; if (rd_hi != rw + 1) begin errors++; $display("FAIL %s read_hold: got %0d expected %0d", nm, rd_hi, rw + 1); end
    end
    @(negedge clk);
    checks++; if ({if0.done, if0.flags_we, if0.busy} !== 3'b000) begin errors++; $display("FAIL %s after_done: done/we/busy=%b expected 000", nm, {if0.done, if0.flags_we, if0.busy}); end
    checks++; if (rd0_n - rb != 1 || rd0_addr !== a) begin errors++; $display("FAIL %s read: count=%0d addr=%h expected 1 %h", nm, rd0_n - rb, rd0_addr, a); end
    checks++;
    if (wq0_a.size() - wb != 2) begin
      errors++; $display("FAIL %s write_count: got %0d expected 2", nm, wq0_a.size() - wb);
    end else begin
      checks++; if (wq0_a[wb] !== a || wq0_d[wb] !== v) begin errors++; $display("FAIL %s dummy_write: got %h/%h expected %h/%h", nm, wq0_a[wb], wq0_d[wb], a, v); end
      checks++; if (wq0_a[wb+1] !== a || wq0_d[wb+1] !== 8'(res)) begin errors++; $display("FAIL %s final_write: got %h/%h expected %h/%h", nm, wq0_a[wb+1], wq0_d[wb+1], a, 8'(res)); end
    end
  endtask

  task automatic run_op1(input logic [4:0] opc, input logic [15:0] a, input logic [7:0] v,
                         input logic cin, input string nm);
    int res, cyc, rb, wb;
    logic [3:0] fv, fm;
    bit got;
    ref_model(int'(opc), int'(v), int'(cin), res, fv, fm);
    mem[a] = v;
    @(negedge clk);
    rb = rd1_n; wb = wq1_a.size();
    if1.start = 1'b1; if1.op = opc; if1.addr = a; if1.carry_in = cin;
    @(posedge clk); #1;
    if1.start = 1'b0; if1.op = 5'($urandom); if1.addr = 16'($urandom);
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if1.done) got = 1;
    end
    checks++; if (!got || cyc != 4) begin errors++; $display("FAIL %s latency: got %0d expected 4", nm, cyc); end
    checks++; if (if1.flags_val !== fv || if1.flags_mask !== fm) begin errors++; $display("FAIL %s flags: got %b/%b expected %b/%b", nm, if1.flags_val, if1.flags_mask, fv, fm); end
    @(negedge clk);
    checks++; if (rd1_n - rb != 1) begin errors++; $display("FAIL %s read_count: got %0d expected 1", nm, rd1_n - rb); end
    checks++;
    if (wq1_a.size() - wb != 1) begin
      errors++; $display("FAIL %s write_count: got %0d expected 1", nm, wq1_a.size() - wb);
    end else begin
      checks++; if (wq1_a[wb] !== a || wq1_d[wb] !== 8'(res)) begin errors++; $display("FAIL %s write: got %h/%h expected %h/%h", nm, wq1_a[wb], wq1_d[wb], a, 8'(res)); end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (outs0() !== '0) begin errors++; $display("FAIL reset_outs0: got %h expected 0", outs0()); end
    checks++; if (outs1() !== '0) begin errors++; $display("FAIL reset_outs1: got %h expected 0", outs1()); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (outs0() !== '0) begin errors++; $display("FAIL idle_outs0: got %h expected 0", outs0()); end
  endtask

  task automatic test_directed();
    run_op0(5'd5, 16'h0200, 8'hFF, 1'b0, 0, 0, "inc_wrap");
    run_op0(5'd6, 16'h0300, 8'h00, 1'b1, 0, 0, "dec_wrap");
    run_op0(5'd10, 16'h1234, 8'h01, 1'b1, 2, 2, "ror_waits");
    run_op0(5'd9, 16'hFFFF, 8'h80, 1'b0, 0, 0, "rol_zero");
    run_op1(5'd8, 16'h0042, 8'h02, 1'b0, "lsr_nodummy");
    run_op1(5'd5, 16'h0043, 8'h7F, 1'b1, "inc_nodummy");
  endtask

  task automatic test_illegal();
    logic [4:0] bad_ops [4];
    int rb, wb, busbad;
    bad_ops = '{5'd2, 5'd0, 5'd11, 5'd31};
    wait_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rb = rd0_n; wb = wq0_a.size(); busbad = 0;
      if0.start = 1'b1; if0.op = bad_ops[i]; if0.addr = 16'h0400;
      @(posedge clk); #1;
      if0.start = 1'b0;
      @(negedge clk);
      checks++; if (if0.error !== 1'b1 || if0.busy !== 1'b0) begin errors++; $display("FAIL illegal_%0d error: error=%b busy=%b expected 1 0", bad_ops[i], if0.error, if0.busy); end
      for (int k = 0; k < 4; k++) begin
        if (if0.mem_rd || if0.mem_wr || if0.busy) busbad++;
        @(negedge clk);
        if (if0.error) busbad++;
      end
      checks++; if (busbad != 0 || rd0_n != rb || wq0_a.size() != wb) begin errors++; $display("FAIL illegal_%0d quiet: violations=%0d reads=%0d writes=%0d expected 0", bad_ops[i], busbad, rd0_n - rb, wq0_a.size() - wb); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, wb;
    mem[16'h0500] = 8'h41;
    wait_mode = 3;
    @(negedge clk);
    if0.start = 1'b1; if0.op = 5'd7; if0.addr = 16'h0500; if0.carry_in = 1'b0;
    @(posedge clk); #1;
    if0.start = 1'b0;
    cyc = 0;
    while (!if0.mem_wr && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != 3 || if0.mem_wr !== 1'b1 || if0.mem_wdata !== 8'h41) begin errors++; $display("FAIL rstmid_write_old: cycle=%0d wr=%b wdata=%h expected 3 1 41", cyc, if0.mem_wr, if0.mem_wdata); end
    wb = wq0_a.size();
    rst = 1'b1;
    #1;
    checks++; if (outs0() !== '0) begin errors++; $display("FAIL rstmid_async: got %h expected 0", outs0()); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_mode = 0;
    repeat (4) @(negedge clk);
    checks++; if (outs0() !== '0 || wq0_a.size() != wb) begin errors++; $display("FAIL rstmid_no_write: outs=%h writes=%0d expected 0 0", outs0(), wq0_a.size() - wb); end
    run_op0(5'd7, 16'h0500, 8'h41, 1'b0, 0, 0, "asl_after_rst");
  endtask

  task automatic test_start_ignored();
    int rb, wb, dones, wes, cyc;
    bit seen;
    mem[16'h0600] = 8'h10;
    wait_mode = 2;
    rd_wait_req = 2;
    @(negedge clk);
    rb = rd0_n; wb = wq0_a.size(); dones = 0; wes = 0; seen = 0;
    if0.start = 1'b1; if0.op = 5'd6; if0.addr = 16'h0600; if0.carry_in = 1'b0;
    @(posedge clk); #1;
    if0.start = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if (if0.done) dones++;
      if (if0.flags_we) wes++;
      if (cyc == 2) begin if0.start = 1'b1; if0.op = 5'd5; if0.addr = 16'h0700; end
      if (if0.done && !seen) begin seen = 1; if0.start = 1'b1; if0.op = 5'd7; end
    end
    checks++; if (dones != 1 || wes != 1) begin errors++; $display("FAIL ignored_start pulses: done=%0d flags_we=%0d expected 1 1", dones, wes); end
    checks++; if (rd0_n - rb != 1 || wq0_a.size() - wb != 2) begin errors++; $display("FAIL ignored_start bus: reads=%0d writes=%0d expected 1 2", rd0_n - rb, wq0_a.size() - wb); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op0(5'($urandom_range(5, 10)), 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), (i % 2), 0, "random");
    end
    for (int i = 0; i < 6; i++) begin
      run_op1(5'($urandom_range(5, 10)), 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), "random_nodummy");
    end
  endtask

  initial begin
    if0.start = 1'b0; if0.op = '0; if0.addr = '0; if0.carry_in = 1'b0;
    if1.start = 1'b0; if1.op = '0; if1.addr = '0; if1.carry_in = 1'b0;
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rmw_sequencer.md
Name: rmw_sequencer

Overview:
Multi-cycle read-modify-write executor for the 6502 memory-operand instructions INC, DEC, ASL, LSR, ROL and ROR. It sits between the control unit and the bus.
- Control side: accepts a start pulse with opcode, effective address and current C flag.
- Bus side: reads the operand, drives the combinational ALU's op/operand/carry inputs, and consumes the ALU's result and {N,V,Z,C} flags.
- Writes back the original value (6502 dummy write) and then the modified value, and returns masked flag updates for the P register.

Parameters:
ADDR_W, 16, width of bus address
DUMMY_WRITE, 1, 1 = issue 6502 dummy write of original value before final write; 0 = skip it

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE
op  input  5  ALU opcode: 5=INC 6=DEC 7=ASL 8=LSR 9=ROL 10=ROR
addr  input  ADDR_W  effective address
carry_in  input  1  current P.C
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse, illegal op rejected
mem_addr  output  ADDR_W  bus address
mem_rd  output  1  read request
mem_wr  output  1  write request
mem_wdata  output  8  write data
mem_rdata  input  8  read data, valid when mem_ready=1 during read
mem_ready  input  1  access completes on a rising edge where request and mem_ready are both high
alu_op  output  5  to ALU
alu_a  output  8  to ALU reg1
alu_b  output  8  to ALU reg2; always 0
alu_cin  output  1  to ALU carry_in
alu_result  input  8  from ALU
alu_flags  input  4  from ALU {N,V,Z,C}
flags_we  output  1  P-register update strobe, coincident with done
flags_val  output  4  {N,V,Z,C} to write
flags_mask  output  4  bits of flags_val to apply

Behaviour:
- Reset (async, rst=1):
  - State → IDLE.
  - All outputs 0: busy, done, error, mem_rd, mem_wr, flags_we, mem_addr, mem_wdata, alu_op, alu_a, alu_cin, flags_val, flags_mask.
  - Reset mid-operation aborts immediately. mem_rd/mem_wr drop asynchronously. No later write is issued.
- Capture: on a start edge in IDLE, op, addr and carry_in are latched. Inputs may change afterwards without effect.
- Illegal op (not 5..10): no bus access; error=1 for one cycle in IDLE; busy stays 0.
- start while busy is ignored; no queuing.
- States:
  - IDLE → READ on legal start.
  - READ: mem_rd=1, mem_addr=addr. Wait while mem_ready=0. On a ready edge, latch operand = mem_rdata → MODIFY.
  - MODIFY, exactly one cycle:
    - Drive alu_op=op, alu_a=operand, alu_b=0, alu_cin=latched carry.
    - Latch result=alu_result and flags=alu_flags.
    - Next state: WRITE_OLD if DUMMY_WRITE=1, else WRITE_NEW.
  - WRITE_OLD: mem_wr=1, mem_wdata=operand. Held until ready edge → WRITE_NEW.
  - WRITE_NEW: mem_wr=1, mem_wdata=result. Held until ready edge → DONE.
  - DONE, one cycle: done=1, flags_we=1 → IDLE. A start in DONE is ignored.
- Request and address/data outputs stay stable throughout wait states. mem_rd and mem_wr are never high together. Outside MODIFY, alu_op=0 and alu_a=0.
- Latency with mem_ready tied high: done is high 5 cycles after the start edge (4 with DUMMY_WRITE=0). Each wait cycle adds 1.
- Flag rules:
  - flags_val = latched ALU flags with V forced to 0.
  - INC/DEC: mask=4'b1010 (N,Z). The ALU's C output is not used.
  - ASL/LSR/ROL/ROR: mask=4'b1011 (N,Z,C).
  - V is never updated.
- Wrap-around is handled entirely by the ALU:
  - INC 0xFF → 0x00, Z=1.
  - DEC 0x00 → 0xFF, N=1.
- No address arithmetic is performed; addr is used unmodified for all three accesses.

Test Plan:
- INC at 0x0200, mem=0xFF, ready tied high → read 0x0200; writes 0xFF then 0x00; done at cycle 5; flags_val=4'b0010, mask=4'b1010.
- ROR at 0x1234, mem=0x01, carry_in=1, 2 wait cycles on the read → mem_rd held 3 cycles; writes 0x01 then 0x80; flags_val=4'b1001, mask=4'b1011; done at cycle 7.
- LSR with DUMMY_WRITE=0, mem=0x02 → single write 0x01; done at cycle 4; flags_val=0, mask=4'b1011.
- op=2 (AND) with start → error pulse one cycle; no mem_rd/mem_wr; busy=0.
- Reset asserted during WRITE_OLD of ASL → mem_wr falls in the same cycle; no WRITE_NEW; all outputs 0. A new start after release completes normally.
- start pulsed again during READ and during DONE → ignored; exactly one done and one flags_we per accepted start.
